// File: rtl/array_serializer.sv
// array_serializer: buffers DEPTH words and shifts them out MSB-first, word 0 first, as one framed serial burst.
module array_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 12,
    parameter int GAP   = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             send,
    output logic             serial_out,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic             wr_rejected
);
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

    state_t           state, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] sreg, sreg_d, word0;
    logic [BW-1:0]    bit_cnt, bit_d;
    logic [AW-1:0]    word_cnt, word_d, nxt;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic             so_d, start_d, done_d, wr_ok;

    assign busy  = state != S_IDLE;
    assign wr_ok = wr_en && !busy && ({1'b0, wr_addr} < DEPTH_W);
    assign nxt   = word_cnt + 1'b1;
    // a same-cycle write to word 0 must reach the frame being launched
    assign word0 = (wr_en && wr_addr == '0) ? wr_data : mem[0];

    always_comb begin
        state_d = state;
        sreg_d  = sreg;
        bit_d   = bit_cnt;
        word_d  = word_cnt;
        gap_d   = gap_cnt;
        so_d    = 1'b0;
        start_d = 1'b0;
        done_d  = 1'b0;
        case (state)
            S_IDLE: if (send) begin
                state_d = S_SHIFT;
                so_d    = word0[WIDTH-1];
                sreg_d  = word0 << 1;
                bit_d   = '0;
                word_d  = '0;
                start_d = 1'b1;
            end
            S_SHIFT: if (bit_cnt == BW'(WIDTH-1)) begin
                bit_d = '0;
                if (word_cnt == AW'(DEPTH-1)) begin
                    word_d  = '0;
                    gap_d   = '0;
                    state_d = (GAP == 0) ? S_IDLE : S_GAP;
                    done_d  = (GAP == 0);
                end else begin
                    word_d = nxt;
                    so_d   = mem[nxt][WIDTH-1];
                    sreg_d = mem[nxt] << 1;
                end
            end else begin
                bit_d  = bit_cnt + 1'b1;
                so_d   = sreg[WIDTH-1];
                sreg_d = sreg << 1;
            end
            S_GAP: if (gap_cnt == GW'(GAP-1)) begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                gap_d   = '0;
            end else begin
                gap_d = gap_cnt + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            sreg        <= '0;
            bit_cnt     <= '0;
            word_cnt    <= '0;
            gap_cnt     <= '0;
            serial_out  <= 1'b0;
            start       <= 1'b0;
            done        <= 1'b0;
            wr_rejected <= 1'b0;
        end else begin
            state       <= state_d;
            sreg        <= sreg_d;
            bit_cnt     <= bit_d;
            word_cnt    <= word_d;
            gap_cnt     <= gap_d;
            serial_out  <= so_d;
            start       <= start_d;
            done        <= done_d;
            wr_rejected <= wr_en && !wr_ok;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end
endmodule

// File: tb/tb_array_serializer.sv
// tb_array_serializer: random write/send traffic checked cycle by cycle against a frame-timing reference model.
module tb_array_serializer;
    localparam int W  = 8;
    localparam int D  = 12;
    localparam int G  = 2;
    localparam int FL = W * D;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic       send = 1'b0;
    logic       serial_out, start, busy, done, wr_rejected;

    int n_chk = 0;
    int n_pass = 0;
    int cyc_n = 0;

    // reference: k = cycles since a frame was accepted, -1 when idle
    int         k = -1;
    logic [7:0] m_mem [D];
    logic [7:0] fr [D];
    logic       e_rej = 1'b0;

    array_serializer #(.WIDTH(W), .DEPTH(D), .GAP(G)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .send(send), .serial_out(serial_out), .start(start), .busy(busy), .done(done),
        .wr_rejected(wr_rejected)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h expected=%h", tag, got, exp);
    endtask

    task automatic model_reset();
        k = -1;
        e_rej = 1'b0;
        for (int i = 0; i < D; i++) m_mem[i] = '0;
    endtask

    task automatic check_outs();
        logic e_so;
        e_so = (k >= 0 && k < FL) ? fr[k / W][W - 1 - (k % W)] : 1'b0;
        chk($sformatf("outs@%0d k=%0d {so,start,busy,done,rej}", cyc_n, k),
            {27'd0, serial_out, start, busy, done, wr_rejected},
            {27'd0, e_so, k == 0, k >= 0 && k < FL + G, k == FL + G, e_rej});
    endtask

    task automatic cyc(input logic s, input logic we, input logic [3:0] a, input logic [7:0] d);
        logic acc;
        @(negedge clk);
        cyc_n++;
        check_outs();
        send = s; wr_en = we; wr_addr = a; wr_data = d;
        acc = (k < 0) || (k == FL + G);
        e_rej = we && (!acc || a >= D);
        if (we && acc && a < D) m_mem[a] = d;
        if (acc && s) begin
            fr = m_mem;
            k = 0;
        end else if (k >= 0 && k < FL + G) k++;
        else k = -1;
    endtask

    initial begin
        model_reset();
        fr = m_mem;
        repeat (2) @(negedge clk);
        chk("reset_outs", {27'd0, serial_out, start, busy, done, wr_rejected}, 32'd0);
        rst_n = 1'b1;
        // all-zero frame straight out of reset
        cyc(1, 0, 0, 0);
        repeat (FL + G + 4) cyc(0, 0, 0, 0);
        // ramp pattern, then single frame
        for (int i = 0; i < D; i++) cyc(0, 1, 4'(i), 8'(8'h10 + i));
        cyc(1, 0, 0, 0);
        repeat (30) cyc(0, 0, 0, 0);
        cyc(1, 1, 4'd3, 8'hFF);
        repeat (FL + G + 4) cyc(0, 0, 0, 0);
        cyc(0, 1, 4'd12, 8'h77);
        cyc(0, 1, 4'd15, 8'h66);
        // send held high: back-to-back frames
        repeat (3 * (FL + G + 1) + 5) cyc(1, 0, 0, 0);
        repeat (5) cyc(0, 0, 0, 0);
        // random traffic including out-of-range addresses and mid-frame requests
        for (int i = 0; i < 1500; i++)
            cyc($urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0, 4'($urandom_range(0, 15)), 8'($urandom));
        repeat (FL + G + 4) cyc(0, 0, 0, 0);
        // A5 into word 0 with the send in the same cycle, rest zero after reset
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1, 1, 4'd0, 8'hA5);
        repeat (FL + G + 4) cyc(0, 0, 0, 0);
        // abort mid-frame at bit 40
        for (int i = 0; i < D; i++) cyc(0, 1, 4'(i), 8'($urandom));
        cyc(1, 0, 0, 0);
        repeat (40) cyc(0, 0, 0, 0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outs", {27'd0, serial_out, start, busy, done, wr_rejected}, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        repeat (FL + G + 4) cyc(0, 0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
